// File: rtl/tx_intf_s_axis_to_pl.sv
// Purpose : strip and decode the two driver header words in front of each DMA TX packet and pass the payload to the PL TX path.
// Latency : payload is forwarded combinationally (0 cycles); header fields, pulses and error flags are registered (1 cycle).
// Backpr. : payload beats follow data_ready_from_pl; header and drain beats are always taken; a new packet waits while tx_hold=1.
//
// Ports
//   clk, rst                     single clock, synchronous active-high reset
//   s_axis_t{data,valid,last}    AXI4-Stream input from the MM2S DMA, s_axis_tready back
//   tx_hold                      blocks the start of a new packet (sampled only between packets)
//   data_to_pl / data_valid_to_pl / data_ready_from_pl   payload handshake to the TX path
//   pkt_hdr_valid, tsf_target, pkt_ht_flag, pkt_rate, pkt_len, pkt_cfg, monitor_num_dma_symbol   decoded header
//   pkt_abort, err_short, err_long, err_clear, tx_pkt_intr   packet end status
//   tlast_timeout_en/top, tsf_pulse_1M, tlast_timeout_recover   stalled-DMA recovery
//
// Build option: define TX_INTF_TLAST_TIMEOUT_RECOVER_EN to include the stalled-DMA timeout.
// Without it the timer is absent, a stalled packet waits forever and tlast_timeout_recover stays 0.
//
// Header layout (64-bit words):
//   word0[63:0]  tsf target
//   word1[52] ht flag, [51:48] rate, [47:32] length in bytes, [7:0] cfg

module tx_intf_s_axis_to_pl #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 64,
  parameter int TSF_TIMER_WIDTH        = 64,
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  input  logic                              tx_hold,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0] data_to_pl,
  output logic                              data_valid_to_pl,
  input  logic                              data_ready_from_pl,
  output logic                              pkt_hdr_valid,
  output logic [TSF_TIMER_WIDTH-1:0]        tsf_target,
  output logic                              pkt_ht_flag,
  output logic [3:0]                        pkt_rate,
  output logic [15:0]                       pkt_len,
  output logic [7:0]                        pkt_cfg,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] monitor_num_dma_symbol,
  output logic                              pkt_abort,
  output logic                              err_short,
  output logic                              err_long,
  input  logic                              err_clear,
  output logic                              tx_pkt_intr,
  input  logic                              tlast_timeout_en,
  input  logic [12:0]                       tlast_timeout_top,
  input  logic                              tsf_pulse_1M,
  output logic                              tlast_timeout_recover
);

  typedef enum logic [1:0] {
    WAIT_HDR0,
    WAIT_HDR1,
    STREAM,
    DRAIN
  } state_t;

  state_t                            state;
  logic [TSF_TIMER_WIDTH-1:0]        tsf_lat;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] word_cnt;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] word_cnt_inc;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] hdr_words;
  logic                              beat;
  logic                              timeout_fire;

  assign beat         = s_axis_tvalid & s_axis_tready;
  assign word_cnt_inc = word_cnt + MAX_BIT_NUM_DMA_SYMBOL'(1);

  // Payload words = ceil(len/8), computed straight from the header1 beat.
  assign hdr_words = MAX_BIT_NUM_DMA_SYMBOL'(s_axis_tdata[47:35])
                   + MAX_BIT_NUM_DMA_SYMBOL'(s_axis_tdata[34:32] != 3'd0);

  // Header1 bits that carry no field.
  logic unused_hdr1_bits;
  assign unused_hdr1_bits = ^{s_axis_tdata[63:53], s_axis_tdata[31:8]};

  // ---------------------------------------------------------------------------
  // Stream handshake. Payload is a straight pass-through in STREAM; everywhere
  // else the TX path sees no valid. Ready is held low during reset so nothing
  // is taken from the DMA while the block is being cleared.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_axis_tready    = 1'b0;
    data_valid_to_pl = 1'b0;
    data_to_pl       = '0;
    if (!rst) begin
      unique case (state)
        WAIT_HDR0: s_axis_tready = !tx_hold;
        WAIT_HDR1: s_axis_tready = 1'b1;
        STREAM: begin
          s_axis_tready    = data_ready_from_pl;
          data_valid_to_pl = s_axis_tvalid;
          data_to_pl       = s_axis_tdata;
        end
        DRAIN:     s_axis_tready = 1'b1;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stalled-DMA timer: counts 1 us ticks while a packet is open, restarts on
  // every accepted beat. It saturates so a long stall with the recovery
  // disabled cannot wrap and fire later by accident.
  // ---------------------------------------------------------------------------
`ifdef TX_INTF_TLAST_TIMEOUT_RECOVER_EN
  logic [13:0] timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (state == WAIT_HDR0 || beat) begin
      timer <= '0;
    end else if (tsf_pulse_1M && timer != '1) begin
      timer <= timer + 14'd1;
    end
  end

  assign timeout_fire = tlast_timeout_en && (state != WAIT_HDR0) &&
                        (timer > {1'b0, tlast_timeout_top});
`else
  logic unused_timeout_inputs;
  assign unused_timeout_inputs = ^{tlast_timeout_en, tlast_timeout_top, tsf_pulse_1M};
  assign timeout_fire          = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Packet FSM with registered header fields, pulses and sticky errors.
  // An accepted beat always wins over a same-cycle timeout. err_clear is
  // applied first so that an error raised in the same cycle survives it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= WAIT_HDR0;
      tsf_lat                <= '0;
      word_cnt               <= '0;
      pkt_hdr_valid          <= 1'b0;
      tsf_target             <= '0;
      pkt_ht_flag            <= 1'b0;
      pkt_rate               <= '0;
      pkt_len                <= '0;
      pkt_cfg                <= '0;
      monitor_num_dma_symbol <= '0;
      pkt_abort              <= 1'b0;
      err_short              <= 1'b0;
      err_long               <= 1'b0;
      tx_pkt_intr            <= 1'b0;
      tlast_timeout_recover  <= 1'b0;
    end else begin
      pkt_hdr_valid         <= 1'b0;
      pkt_abort             <= 1'b0;
      tx_pkt_intr           <= 1'b0;
      tlast_timeout_recover <= 1'b0;

      if (err_clear) begin
        err_short <= 1'b0;
        err_long  <= 1'b0;
      end

      if (beat) begin
        unique case (state)
          WAIT_HDR0: begin
            tsf_lat <= s_axis_tdata[TSF_TIMER_WIDTH-1:0];
            if (s_axis_tlast) begin
              // A packet that is only one word long has no header1 at all.
              err_short   <= 1'b1;
              pkt_abort   <= 1'b1;
              tx_pkt_intr <= 1'b1;
            end else begin
              state <= WAIT_HDR1;
            end
          end

          WAIT_HDR1: begin
            // tsf_target is published together with header1 so that all
            // header outputs change at once, on the pkt_hdr_valid pulse.
            pkt_hdr_valid          <= 1'b1;
            tsf_target             <= tsf_lat;
            pkt_ht_flag            <= s_axis_tdata[52];
            pkt_rate               <= s_axis_tdata[51:48];
            pkt_len                <= s_axis_tdata[47:32];
            pkt_cfg                <= s_axis_tdata[7:0];
            monitor_num_dma_symbol <= hdr_words;
            word_cnt               <= '0;
            if (hdr_words == '0) begin
              if (s_axis_tlast) begin
                tx_pkt_intr <= 1'b1;
                state       <= WAIT_HDR0;
              end else begin
                err_long <= 1'b1;
                state    <= DRAIN;
              end
            end else if (s_axis_tlast) begin
              err_short   <= 1'b1;
              pkt_abort   <= 1'b1;
              tx_pkt_intr <= 1'b1;
              state       <= WAIT_HDR0;
            end else begin
              state <= STREAM;
            end
          end

          STREAM: begin
            if (s_axis_tlast) begin
              tx_pkt_intr <= 1'b1;
              word_cnt    <= '0;
              state       <= WAIT_HDR0;
              // The counter never passes the expected count in STREAM, so a
              // mismatch here can only mean the packet ended early.
              if (word_cnt_inc != monitor_num_dma_symbol) begin
                err_short <= 1'b1;
                pkt_abort <= 1'b1;
              end
            end else if (word_cnt_inc == monitor_num_dma_symbol) begin
              // Last expected word without tlast: the rest is surplus.
              err_long <= 1'b1;
              word_cnt <= '0;
              state    <= DRAIN;
            end else begin
              word_cnt <= word_cnt_inc;
            end
          end

          DRAIN: begin
            if (s_axis_tlast) begin
              pkt_abort   <= 1'b1;
              tx_pkt_intr <= 1'b1;
              state       <= WAIT_HDR0;
            end
          end
        endcase
      end else if (timeout_fire) begin
        // Header fields are left as they were; only the packet is closed.
        tlast_timeout_recover <= 1'b1;
        pkt_abort             <= 1'b1;
        tx_pkt_intr           <= 1'b1;
        word_cnt              <= '0;
        state                 <= WAIT_HDR0;
      end
    end
  end

endmodule

// File: tb/tb_tx_intf_s_axis_to_pl.sv
// Purpose : stimulus and checking for tx_intf_s_axis_to_pl.
// Latency : n/a (testbench).
// Backpr. : drives data_ready_from_pl always-on, toggling or random per packet.

module tb_tx_intf_s_axis_to_pl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        tx_hold;
  logic [63:0] data_to_pl;
  logic        data_valid_to_pl;
  logic        data_ready_from_pl;
  logic        pkt_hdr_valid;
  logic [63:0] tsf_target;
  logic        pkt_ht_flag;
  logic [3:0]  pkt_rate;
  logic [15:0] pkt_len;
  logic [7:0]  pkt_cfg;
  logic [13:0] monitor_num_dma_symbol;
  logic        pkt_abort;
  logic        err_short;
  logic        err_long;
  logic        err_clear;
  logic        tx_pkt_intr;
  logic        tlast_timeout_en;
  logic [12:0] tlast_timeout_top;
  logic        tsf_pulse_1M;
  logic        tlast_timeout_recover;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;   // 0: always ready, 1: toggle every cycle, 2: random

  // Observation counters, written only by the monitor process.
  logic [63:0] fwd_q[$];
  int hdr_cnt = 0;
  int intr_cnt = 0;
  int abort_cnt = 0;
  int rec_cnt = 0;
  int mirror_err = 0;

  always #5 clk = ~clk;

  tx_intf_s_axis_to_pl dut (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_tdata           (s_axis_tdata),
    .s_axis_tvalid          (s_axis_tvalid),
    .s_axis_tlast           (s_axis_tlast),
    .s_axis_tready          (s_axis_tready),
    .tx_hold                (tx_hold),
    .data_to_pl             (data_to_pl),
    .data_valid_to_pl       (data_valid_to_pl),
    .data_ready_from_pl     (data_ready_from_pl),
    .pkt_hdr_valid          (pkt_hdr_valid),
    .tsf_target             (tsf_target),
    .pkt_ht_flag            (pkt_ht_flag),
    .pkt_rate               (pkt_rate),
    .pkt_len                (pkt_len),
    .pkt_cfg                (pkt_cfg),
    .monitor_num_dma_symbol (monitor_num_dma_symbol),
    .pkt_abort              (pkt_abort),
    .err_short              (err_short),
    .err_long               (err_long),
    .err_clear              (err_clear),
    .tx_pkt_intr            (tx_pkt_intr),
    .tlast_timeout_en       (tlast_timeout_en),
    .tlast_timeout_top      (tlast_timeout_top),
    .tsf_pulse_1M           (tsf_pulse_1M),
    .tlast_timeout_recover  (tlast_timeout_recover)
  );

  // Inputs change just after posedge, so the negedge view equals what the
  // next posedge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid_to_pl && data_ready_from_pl) fwd_q.push_back(data_to_pl);
      if (data_valid_to_pl && (s_axis_tready !== data_ready_from_pl)) mirror_err++;
      if (pkt_hdr_valid) hdr_cnt++;
      if (tx_pkt_intr) intr_cnt++;
      if (pkt_abort) abort_cnt++;
      if (tlast_timeout_recover) rec_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat until accepted; returns one step after the accepting edge.
  task automatic send_beat(input string tag, input logic [63:0] d, input logic l);
    logic acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      guard++;
      if (rdy_mode == 1) data_ready_from_pl = ~data_ready_from_pl;
      else if (rdy_mode == 2) data_ready_from_pl = 1'($urandom_range(0, 1));
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!acc) check({tag, "_accept_timeout"}, 64'(acc), 64'd1);
  endtask

  function automatic logic [63:0] mk_hdr1(input logic [15:0] len, input logic [3:0] rate,
                                          input logic ht, input logic [7:0] cfg);
    logic [10:0] junk_hi;
    logic [23:0] junk_mid;
    junk_hi  = 11'($urandom);
    junk_mid = 24'($urandom);
    return {junk_hi, ht, rate, len, junk_mid, cfg};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({s_axis_tready, data_valid_to_pl, pkt_hdr_valid, pkt_ht_flag, pkt_abort,
                               err_short, err_long, tx_pkt_intr, tlast_timeout_recover}), 64'd0);
    check({tag, "_data"}, data_to_pl, 64'd0);
    check({tag, "_tsf"}, tsf_target, 64'd0);
    check({tag, "_hdr"}, 64'({pkt_rate, pkt_len, pkt_cfg, monitor_num_dma_symbol}), 64'd0);
  endtask

  // One full packet: header0, header1, k payload words, tlast on the final beat.
  // Reference: n = ceil(len/8); the first min(k,n) words reach the PL side;
  // k<n is short, k>n is long, any k!=n aborts; every packet interrupts once.
  task automatic run_pkt(input string tag, input logic [63:0] tsf, input logic [15:0] len,
                         input logic [3:0] rate, input logic ht, input logic [7:0] cfg,
                         input int k, input int mode, input logic hold_mid, input logic clr_on_last);
    int n, nfwd, q0, h0, i0, a0;
    logic exp_short, exp_long, exp_abort;
    logic [63:0] words[$];
    logic [63:0] w;
    n = (int'(len) + 7) / 8;
    nfwd = (k < n) ? k : n;
    exp_short = (k < n);
    exp_long  = (k > n);
    exp_abort = (k != n);

    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    check({tag, "_err_cleared"}, 64'({err_short, err_long}), 64'd0);

    rdy_mode = mode;
    data_ready_from_pl = 1'b1;
    q0 = fwd_q.size();
    h0 = hdr_cnt;
    i0 = intr_cnt;
    a0 = abort_cnt;

    send_beat({tag, "_h0"}, tsf, 1'b0);
    if (hold_mid) tx_hold = 1'b1;
    if (clr_on_last && k == 0) err_clear = 1'b1;
    send_beat({tag, "_h1"}, mk_hdr1(len, rate, ht, cfg), k == 0);
    err_clear = 1'b0;
    check({tag, "_hdr_valid"}, 64'(pkt_hdr_valid), 64'd1);
    check({tag, "_tsf"}, tsf_target, tsf);
    check({tag, "_fields"}, 64'({pkt_ht_flag, pkt_rate, pkt_len, pkt_cfg}), 64'({ht, rate, len, cfg}));
    check({tag, "_nsym"}, 64'(monitor_num_dma_symbol), 64'(n));

    for (int i = 1; i <= k; i++) begin
      w = {$urandom, $urandom};
      words.push_back(w);
      if (clr_on_last && i == k) err_clear = 1'b1;
      send_beat({tag, "_d"}, w, i == k);
      err_clear = 1'b0;
    end

    // One cycle after the tlast beat.
    check({tag, "_intr"}, 64'(tx_pkt_intr), 64'd1);
    check({tag, "_abort"}, 64'(pkt_abort), 64'(exp_abort));
    check({tag, "_err"}, 64'({err_short, err_long}), 64'({exp_short, exp_long}));

    rdy_mode = 0;
    data_ready_from_pl = 1'b1;
    tx_hold = 1'b0;
    idle(2);
    check({tag, "_hdr_cnt"}, 64'(hdr_cnt - h0), 64'd1);
    check({tag, "_intr_cnt"}, 64'(intr_cnt - i0), 64'd1);
    check({tag, "_abort_cnt"}, 64'(abort_cnt - a0), 64'(exp_abort));
    check({tag, "_mirror"}, 64'(mirror_err), 64'd0);
    check({tag, "_nfwd"}, 64'(fwd_q.size() - q0), 64'(nfwd));
    if (fwd_q.size() - q0 == nfwd) begin
      for (int i = 0; i < nfwd; i++) check({tag, "_word"}, fwd_q[q0 + i], words[i]);
    end
  endtask

  initial begin
    int i0, r0, q0, n, k, found;
    logic [15:0] rlen;

    rst = 1'b1;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    tx_hold = 1'b0;
    data_ready_from_pl = 1'b1;
    err_clear = 1'b0;
    tlast_timeout_en = 1'b0;
    tlast_timeout_top = 13'd0;
    tsf_pulse_1M = 1'b0;
    idle(3);
    check_all_zero("reset");
    rst = 1'b0;
    idle(1);
    check("ready_after_reset", 64'(s_axis_tready), 64'd1);

    // Nominal packet, always-ready sink.
    run_pkt("t1", 64'h1122334455667788, 16'd100, 4'hB, 1'b0, 8'h5A, 13, 0, 1'b0, 1'b0);
    // Same packet with a toggling sink and a mid-packet tx_hold that must be ignored.
    run_pkt("t2", 64'h0123456789ABCDEF, 16'd100, 4'hB, 1'b0, 8'hA5, 13, 1, 1'b1, 1'b0);
    // Early tlast; err_clear on the same beat must lose.
    run_pkt("t3", 64'hDEADBEEF00000001, 16'd100, 4'h3, 1'b1, 8'h01, 5, 0, 1'b0, 1'b1);
    // Too many words: first two forwarded, rest drained.
    run_pkt("t4", 64'h0000000000000ABC, 16'd16, 4'h7, 1'b0, 8'h10, 5, 0, 1'b0, 1'b0);
    // Zero-length packet ending on header1, and zero-length with surplus words.
    run_pkt("z0", 64'h5555AAAA5555AAAA, 16'd0, 4'h1, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);
    run_pkt("z2", 64'hAAAA5555AAAA5555, 16'd0, 4'h2, 1'b1, 8'hFF, 2, 2, 1'b0, 1'b0);
    // Non-zero length ending on header1, and a non-multiple-of-8 length.
    run_pkt("h1last", 64'h1, 16'd9, 4'h4, 1'b0, 8'h33, 0, 0, 1'b0, 1'b0);
    run_pkt("len9", 64'h2, 16'd9, 4'h4, 1'b1, 8'h44, 2, 2, 1'b0, 1'b0);

    // Randomized packets against the reference rule.
    for (int p = 0; p < 6; p++) begin
      rlen = 16'($urandom_range(0, 80));
      n = (int'(rlen) + 7) / 8;
      k = $urandom_range((n > 2) ? n - 2 : 0, n + 2);
      run_pkt("rnd", {$urandom, $urandom}, rlen, 4'($urandom), 1'($urandom), 8'($urandom),
              k, $urandom_range(0, 2), 1'b0, 1'b0);
    end

    // Header0 that carries tlast.
    i0 = intr_cnt;
    send_beat("h0last", 64'h77, 1'b1);
    check("h0last_short", 64'({err_short, pkt_abort, tx_pkt_intr}), 64'b111);
    idle(2);
    check("h0last_intr_cnt", 64'(intr_cnt - i0), 64'd1);

    // tx_hold between packets blocks the header.
    tx_hold = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 64'h99;
    idle(1);
    check("hold_ready", 64'(s_axis_tready), 64'd0);
    idle(2);
    check("hold_ready_still", 64'(s_axis_tready), 64'd0);
    s_axis_tvalid = 1'b0;
    tx_hold = 1'b0;
    idle(1);

    // Reset in the middle of a payload.
    send_beat("rst_h0", 64'hCAFE, 1'b0);
    send_beat("rst_h1", mk_hdr1(16'd100, 4'h5, 1'b0, 8'h0C), 1'b0);
    for (int i = 0; i < 3; i++) send_beat("rst_d", {$urandom, $urandom}, 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 64'h1234;
    rst = 1'b1;
    idle(1);
    check_all_zero("midrst");
    s_axis_tvalid = 1'b0;
    rst = 1'b0;
    idle(1);
    run_pkt("after_rst", 64'h600D, 16'd24, 4'h6, 1'b0, 8'h66, 3, 0, 1'b0, 1'b0);

`ifdef TX_INTF_TLAST_TIMEOUT_RECOVER_EN
    // Stalled source after header1; top=10 fires on the 11th tick.
    tlast_timeout_en = 1'b1;
    tlast_timeout_top = 13'd10;
    i0 = intr_cnt;
    r0 = rec_cnt;
    send_beat("to_h0", 64'hABCDEF, 1'b0);
    send_beat("to_h1", mk_hdr1(16'd100, 4'h9, 1'b0, 8'h21), 1'b0);
    for (int p = 0; p < 10; p++) begin
      tsf_pulse_1M = 1'b1;
      idle(1);
      tsf_pulse_1M = 1'b0;
      idle(3);
    end
    check("to_not_early", 64'(rec_cnt - r0), 64'd0);
    tsf_pulse_1M = 1'b1;
    idle(1);
    tsf_pulse_1M = 1'b0;
    found = 0;
    for (int c = 0; c < 6 && found == 0; c++) begin
      if (tlast_timeout_recover === 1'b1) begin
        found = 1;
        check("to_abort", 64'(pkt_abort), 64'd1);
        check("to_intr", 64'(tx_pkt_intr), 64'd1);
      end else begin
        idle(1);
      end
    end
    check("to_fired", 64'(found), 64'd1);
    check("to_len_held", 64'(pkt_len), 64'd100);
    idle(2);
    check("to_intr_cnt", 64'(intr_cnt - i0), 64'd1);
    tlast_timeout_en = 1'b0;
    run_pkt("to_next", 64'h4242, 16'd8, 4'h1, 1'b0, 8'h02, 1, 0, 1'b0, 1'b0);
`else
    // Without the timeout build a stalled packet simply waits.
    tlast_timeout_en = 1'b1;
    tlast_timeout_top = 13'd0;
    i0 = intr_cnt;
    r0 = rec_cnt;
    q0 = fwd_q.size();
    send_beat("st_h0", 64'hABCDEF, 1'b0);
    send_beat("st_h1", mk_hdr1(16'd16, 4'h9, 1'b0, 8'h21), 1'b0);
    for (int p = 0; p < 6; p++) begin
      tsf_pulse_1M = 1'b1;
      idle(1);
      tsf_pulse_1M = 1'b0;
      idle(2);
    end
    check("st_no_recover", 64'(rec_cnt - r0), 64'd0);
    check("st_no_intr", 64'(intr_cnt - i0), 64'd0);
    send_beat("st_d1", 64'h1111, 1'b0);
    send_beat("st_d2", 64'h2222, 1'b1);
    check("st_end_intr", 64'(tx_pkt_intr), 64'd1);
    idle(2);
    check("st_nfwd", 64'(fwd_q.size() - q0), 64'd2);
    tlast_timeout_en = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
